addsub_div_sequencer: RTL and testbench

Multi-cycle unsigned restoring divider built around the existing 32-bit adder/subtractor (`part_5_top_module`, ports a, b, sub, sum). The block holds the partial remainder and quotient registers and a cycle counter, and drives the shared adder in subtract mode once per cycle to produce one quotient bit per clock. It sits beside the adder in the lab1 datapath as its first sequencing controller, with a start/done handshake toward the surrounding logic.

---
 rtl/addsub_div_sequencer_pkg.sv | 9 +
 rtl/part_5_top_module.sv | 11 +
 rtl/addsub_div_sequencer.sv | 110 +++++++++++
 tb/tb_addsub_div_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/addsub_div_sequencer_pkg.sv
// addsub_div_sequencer_pkg: shared state encodings and default operand width for the divider sequencer.
package addsub_div_sequencer_pkg;
    localparam int WIDTH_DEF = 32;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;
endpackage

// File: rtl/part_5_top_module.sv
// part_5_top_module: combinational adder/subtractor; sub=1 yields a-b modulo 2^W.
module part_5_top_module #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);
    assign sum = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};
endmodule

// File: rtl/addsub_div_sequencer.sv
// addsub_div_sequencer: restoring divider, one quotient bit per clock via the shared adder/subtractor.
// A zero divisor spends one busy cycle in RUN without iterating, then reports all-ones / dividend.
module addsub_div_sequencer
    import addsub_div_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d, q_q, q_d, r_q, r_d, quot_q, quot_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             z_q, z_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] s, add_a, add_b, add_sum;
    logic             add_sub, qb;

    part_5_top_module #(.W(WIDTH)) u_addsub (
        .a  (add_a),
        .b  (add_b),
        .sub(add_sub),
        .sum(add_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (cnt_q == '0) ? FIN : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = state_q == RUN;
        done    = state_q == FIN;
        add_sub = busy;
        add_a   = busy ? s : '0;
        add_b   = busy ? d_q : '0;
    end

    // r_q[WIDTH-1] is the bit shifted out of the remainder; when set, S+2^WIDTH >= D always holds.
    always_comb begin
        s      = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        qb     = r_q[WIDTH-1] | (s >= d_q);
        d_d    = d_q;
        q_d    = q_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        z_d    = z_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (state_q == IDLE && start) begin
            d_d   = divisor;
            q_d   = dividend;
            r_d   = '0;
            z_d   = divisor == '0;
            cnt_d = (divisor == '0) ? '0 : CW'(WIDTH - 1);
        end
        if (state_q == RUN && !z_q) begin
            r_d   = qb ? add_sum : s;
            q_d   = {q_q[WIDTH-2:0], qb};
            cnt_d = cnt_q - CW'(1);
        end
        if (state_q == RUN && cnt_q == '0) begin
            quot_d = z_q ? '1 : q_d;
            rem_d  = z_q ? q_q : r_d;
            dbz_d  = z_q;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_addsub_div_sequencer.sv
// tb_addsub_div_sequencer: directed and random divisions checked against integer / and % reference.
module tb_addsub_div_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    addsub_div_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and follows it to done; expectations come from plain integer division.
    task automatic run_div(input logic [31:0] dd, input logic [31:0] dv);
        int n, nb;
        bit seen;
        logic [31:0] eq, er;
        eq = (dv == 0) ? 32'hFFFF_FFFF : dd / dv;
        er = (dv == 0) ? dd : dd % dv;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        n = 0; nb = 0; seen = 0;
        while (!seen && n < 60) begin
            nb += int'(busy);
            tick();
            n++;
            seen = done;
        end
        chk("latency", n + 1, (dv == 0) ? 2 : 33);
        chk("busy_cycles", nb, (dv == 0) ? 1 : 32);
        chk("busy_at_done", busy, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, dv == 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("quotient_held", quotient, eq);
        chk("remainder_held", remainder, er);
    endtask

    initial begin
        int n, hits;
        logic [31:0] dd, dv;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_div(32'd100, 32'd7);
        run_div(32'hFFFF_FFFF, 32'h8000_0000);
        run_div(32'hFFFF_FFFF, 32'd1);
        run_div(32'd7, 32'd9);
        run_div(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_div(32'd5, 32'd0);
        run_div(32'd9, 32'd3);

        // A second start in the middle of an operation must not disturb it.
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        n = 10;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk("ignored_start_latency", n + 1, 33);
        chk("ignored_start_quotient", quotient, 14);
        chk("ignored_start_remainder", remainder, 2);
        tick();

        // Asynchronous reset mid-operation clears everything at once and produces no done.
        run_div(32'd5, 32'd0);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        tick();
        tick();
        rst_n = 1'b1;
        hits = 0;
        repeat (40) begin
            tick();
            hits += int'(done) + int'(busy);
        end
        chk("abort_no_activity", hits, 0);
        run_div(32'd40, 32'd6);

        for (int i = 0; i < 20; i++) begin
            dd = $urandom;
            dv = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : ($urandom >> $urandom_range(0, 31));
            run_div(dd, dv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
